// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone B3 arbiter with round-robin fairness.
// A grant lasts for a whole cyc; a per-transfer watchdog turns a missing response into err.
module wb_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  input  logic [AW*NUM_MASTERS-1:0]   wbm_adr_i,
  input  logic [DW*NUM_MASTERS-1:0]   wbm_dat_i,
  input  logic [(DW/8)*NUM_MASTERS-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [3*NUM_MASTERS-1:0]    wbm_cti_i,
  input  logic [2*NUM_MASTERS-1:0]    wbm_bte_i,
  output logic [DW*NUM_MASTERS-1:0]   wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [DW-1:0]               wbs_dat_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [DW-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        timeout_o
);

  localparam int unsigned SW   = DW / 8;
  localparam int unsigned OwW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [OwW-1:0] LastInit = OwW'(NUM_MASTERS - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [OwW-1:0]  owner_q, owner_d;
  logic [OwW-1:0]  last_owner_q, last_owner_d;
  logic [CntW-1:0] wd_cnt_q, wd_cnt_d;

  logic [AW-1:0] adr_lane [NUM_MASTERS];
  logic [DW-1:0] dat_lane [NUM_MASTERS];
  logic [SW-1:0] sel_lane [NUM_MASTERS];
  logic [2:0]    cti_lane [NUM_MASTERS];
  logic [1:0]    bte_lane [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_lane
    assign adr_lane[g] = wbm_adr_i[g*AW +: AW];
    assign dat_lane[g] = wbm_dat_i[g*DW +: DW];
    assign sel_lane[g] = wbm_sel_i[g*SW +: SW];
    assign cti_lane[g] = wbm_cti_i[g*3 +: 3];
    assign bte_lane[g] = wbm_bte_i[g*2 +: 2];
  end

  logic own_cyc, own_stb, slv_resp, wd_fire;

  assign own_cyc  = wbm_cyc_i[owner_q];
  assign own_stb  = own_cyc & wbm_stb_i[owner_q];
  assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

  // Scan starts just after the previous owner and wraps modulo NUM_MASTERS.
  logic [OwW-1:0] pick_idx, scan_idx;
  logic           pick_vld;

  always_comb begin
    pick_idx = last_owner_q;
    pick_vld = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      scan_idx = OwW'((32'(last_owner_q) + i) % NUM_MASTERS);
      if (!pick_vld && wbm_cyc_i[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wd_cnt_d     = '0;
    wd_fire      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d = StBusy;
          owner_d = pick_idx;
        end
      end
      StBusy: begin
        if (own_stb && !slv_resp && (TIMEOUT != 0)) begin
          if (32'(wd_cnt_q) == TIMEOUT - 1) begin
            wd_fire = 1'b1;
          end else begin
            wd_cnt_d = wd_cnt_q + CntW'(1);
          end
        end
        if (!own_cyc) begin
          state_d      = StIdle;
          last_owner_d = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_owner_q <= LastInit;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    grant_o   = '0;
    timeout_o = wd_fire;
    if (state_q == StBusy) begin
      wbs_adr_o          = adr_lane[owner_q];
      wbs_dat_o          = dat_lane[owner_q];
      wbs_sel_o          = sel_lane[owner_q];
      wbs_we_o           = wbm_we_i[owner_q];
      wbs_cyc_o          = own_cyc;
      wbs_stb_o          = own_stb;
      wbs_cti_o          = cti_lane[owner_q];
      wbs_bte_o          = bte_lane[owner_q];
      // A real response in the same cycle suppresses the forced err via wd_fire.
      wbm_ack_o[owner_q] = wbs_ack_i;
      wbm_err_o[owner_q] = wbs_err_i | wd_fire;
      wbm_rty_o[owner_q] = wbs_rty_i;
      grant_o[owner_q]   = 1'b1;
    end
  end

  assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Parametrised N-master to 1-slave Wishbone B3 arbiter with round-robin fairness. It holds a grant for a whole cycle, including registered-feedback bursts.
- It adds a per-transfer ack watchdog that terminates hung transfers with err.
- It sits between the per-core flattened or1k i/d buses and the shared memory or UART slave. It replaces fixed-priority muxing as NUM_CORES grows.

Parameters:
- NUM_MASTERS, 2, number of masters (>=1); flattened bus lanes are indexed i*width.
- AW, 32, address width.
- DW, 32, data width; SEL width is DW/8.
- TIMEOUT, 1024, cycles an active stb may wait for ack/err/rty before a forced err; 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_n_i  in  1  synchronous active-low reset.
- wbm_adr_i  in  AW*NUM_MASTERS  master addresses.
- wbm_dat_i  in  DW*NUM_MASTERS  master write data.
- wbm_sel_i  in  (DW/8)*NUM_MASTERS  byte selects.
- wbm_we_i / wbm_cyc_i / wbm_stb_i  in  NUM_MASTERS each  per-master controls.
- wbm_cti_i  in  3*NUM_MASTERS;  wbm_bte_i  in  2*NUM_MASTERS.
- wbm_dat_o  out  DW*NUM_MASTERS  read data.
- wbm_ack_o / wbm_err_o / wbm_rty_o  out  NUM_MASTERS each.
- wbs_adr_o AW, wbs_dat_o DW, wbs_sel_o DW/8, wbs_we_o 1, wbs_cyc_o 1, wbs_stb_o 1, wbs_cti_o 3, wbs_bte_o 2  out  slave side.
- wbs_dat_i DW, wbs_ack_i 1, wbs_err_i 1, wbs_rty_i 1  in  slave responses.
- grant_o  out  NUM_MASTERS  one-hot current owner; all-zero when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset is wb_rst_n_i, synchronous, active-low. All state updates on the rising edge.
- Reset values:
  - state=IDLE, grant_o=0, timeout_o=0.
  - last_owner=NUM_MASTERS-1, so master 0 wins first.
  - watchdog count=0.
  - All wbs_* control outputs 0; all wbm ack/err/rty 0.
- FSM IDLE:
  - Slave cyc/stb/we forced 0.
  - If any wbm_cyc_i[k] is high, pick the first requester scanning (last_owner+1) mod N upward with wrap. Register owner, go BUSY.
  - Arbitration latency is exactly 1 cycle from cyc seen to wbs_cyc_o.
- FSM BUSY:
  - wbs_* driven combinationally from the owner's lane: adr/dat/sel/we/cti/bte, cyc=owner cyc, stb=owner cyc&stb.
  - Owner gets wbs_ack_i/err_i/rty_i. Other masters get 0.
  - wbm_dat_o replicates wbs_dat_i on every lane.
- Leaving BUSY: when the owner's cyc drops, next state is IDLE, last_owner<=owner, grant_o<=0. There is one bubble cycle minimum between owners, and the same master may not re-win that edge unless it is the only requester.
- Bursts: cti=001/010 beats stay granted while cyc is held. Other masters never interrupt, whatever their cyc or cti.
- Single master (NUM_MASTERS=1): owner index fixed at 0; the FSM still applies.
- Watchdog counter:
  - Increments each BUSY cycle with owner stb=1 and no ack/err/rty.
  - Clears on any response, on stb low, or in IDLE.
  - When count==TIMEOUT-1 with still no response: owner gets wbm_err_o=1 that cycle, timeout_o=1 for one cycle, count<=0.
  - Simultaneous real ack on that cycle: ack wins, no forced err.
- Slave err/rty pass through unchanged and do not release the grant; only cyc deassertion releases it.
- Reset mid-BUSY: next edge returns to reset values regardless of cyc or pending response.
- Widths: owner index is max(1,clog2(NUM_MASTERS)) bits. Wrap computed modulo NUM_MASTERS, not a power of two.

Test Plan:
- Reset low 3 cycles, then masters 0,1 both raise cyc/stb -> wbs_cyc_o rises 1 cycle later, grant_o=2'b01; after m0 drops cyc, idle 1 cycle, grant_o=2'b10.
- NUM_MASTERS=3, all requesting continuously with single-beat cycles -> grant order 0,1,2,0,1,2; each owner's cycle is followed by a 1-cycle bubble (grant_o=0).
- m1 runs a 4-beat incrementing burst (cti 010,010,010,111) while m0 requests -> m0 sees no ack until m1 cyc drops; wbs_adr_o tracks m1 for all 4 beats.
- TIMEOUT=8, slave never acks -> owner wbm_err_o=1 and timeout_o=1 on the 8th stb cycle; counter restarts; ack arriving on that exact cycle -> ack only, no err.
- wbs_rty_i from slave -> rty on owner only; grant held until owner drops cyc.
- Reset asserted mid-burst -> next cycle grant_o=0, wbs_cyc_o=0; after release, master 0 wins first.
